// File: rtl/jtag_pkg.sv
// -----------------------------------------------------------------------------
// jtag_pkg
// Shared types and constants for the host-side JTAG scan engine.
//   scan_state_e : scan FSM states
//   HDR_DR/HDR_IR: TMS header patterns from Run-Test/Idle to Shift-DR/Shift-IR,
//                  shifted LSB first
//   TAP_RST_BITS : bits in the TAP reset sequence (5x TMS=1, then TMS=0)
//   TAIL_BITS    : bits from Exit1 back to Run-Test/Idle (Update, Idle)
// -----------------------------------------------------------------------------
package jtag_pkg;

  typedef enum logic [2:0] {
    TAP_RST,
    IDLE,
    HDR,
    SHIFT,
    TAIL,
    RESP
  } scan_state_e;

  localparam logic [2:0] HDR_DR       = 3'b001;
  localparam logic [3:0] HDR_IR       = 4'b0011;
  localparam int         TAP_RST_BITS = 6;
  localparam int         TAIL_BITS    = 2;

  // Number of header bits for an IR or DR scan.
  function automatic logic [5:0] hdr_bits(input logic ir);
    return ir ? 6'd4 : 6'd3;
  endfunction

  // TMS value of header bit idx.
  function automatic logic hdr_tms(input logic ir, input logic [5:0] idx);
    logic [3:0] pat;
    pat = ir ? HDR_IR : {1'b0, HDR_DR};
    return pat[idx[1:0]];
  endfunction

endpackage

// File: rtl/jtag_tck_gen.sv
// -----------------------------------------------------------------------------
// jtag_tck_gen
// TCK divider: while enabled, issues a tick every CLK_DIV clk cycles and each
// tick toggles TCK. The tick that drives TCK 0->1 is flagged on rise_tick, the
// one that drives TCK 1->0 on fall_tick; both are valid in the cycle before the
// edge that moves TCK. When disabled the counter is held at zero and TCK keeps
// its value (the caller only disables it after a falling edge, so TCK idles low).
// Ports:
//   clk, sys_rst   : clock, synchronous active-high reset
//   en             : run the divider
//   tck            : registered JTAG clock
//   rise_tick      : the next clk edge drives TCK 0->1
//   fall_tick      : the next clk edge drives TCK 1->0
// -----------------------------------------------------------------------------
module jtag_tck_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic sys_rst,
  input  logic en,
  output logic tck,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tck_q, tck_d;
  logic          tick;

  assign tick      = en && (cnt_q == CW'(CLK_DIV - 1));
  assign rise_tick = tick & ~tck_q;
  assign fall_tick = tick &  tck_q;
  assign tck       = tck_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave
    // it unassigned, which is what would otherwise infer a latch.
    cnt_d = cnt_q;
    tck_d = tck_q;
    if (!en) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
      tck_d = ~tck_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering in simulation.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      cnt_q <= '0;
      tck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tck_q <= tck_d;
    end
  end

endmodule

// File: rtl/jtag_host_scan.sv
// -----------------------------------------------------------------------------
// jtag_host_scan
// Host-side JTAG scan engine. Takes IR/DR scan commands on a valid/ready
// channel, drives the TAP pins so that every scan starts and ends in
// Run-Test/Idle, and returns the captured TDO bits on a valid/ready response
// channel. A zero-length command re-runs the TAP reset sequence instead.
// Ports:
//   clk, sys_rst          : clock, synchronous active-high reset
//   cmd_valid/cmd_ready   : command handshake (one command outstanding)
//   cmd_ir                : 1 = IR scan, 0 = DR scan
//   cmd_len               : bits to shift; 0 = TAP reset; >MAX_LEN clamped
//   cmd_data              : TDI bits, LSB first
//   rsp_valid/rsp_ready   : response handshake
//   rsp_data              : captured TDO bits, bit i = i-th shifted bit
//   TCK/TMS/TDI/TDO       : JTAG pins
//   jtag_rst_n            : target TAP reset, registered ~sys_rst
// -----------------------------------------------------------------------------
module jtag_host_scan
  import jtag_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int MAX_LEN = 32
) (
  input  logic               clk,
  input  logic               sys_rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_ir,
  input  logic [5:0]         cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               TCK,
  output logic               TMS,
  output logic               TDI,
  input  logic               TDO,
  output logic               jtag_rst_n
);

  localparam int         IDXW     = $clog2(MAX_LEN);
  localparam logic [5:0] MAX_LEN6 = 6'(MAX_LEN);

  scan_state_e        state_q, state_d;
  logic [5:0]         bit_q, bit_d;
  logic [5:0]         len_q, len_d;
  logic               ir_q, ir_d;
  logic               cmd_rst_q, cmd_rst_d;
  logic               tms_q, tms_d;
  logic               tdi_q, tdi_d;
  logic [MAX_LEN-1:0] data_q, data_d;
  logic [MAX_LEN-1:0] cap_q, cap_d;
  logic [MAX_LEN-1:0] rsp_data_q, rsp_data_d;
  logic               jtag_rst_n_q;

  logic               tck_en;
  logic               rise_tick, fall_tick;
  logic [5:0]         cmd_len_eff;

  // The divider only runs while the TAP pins are in motion.
  assign tck_en = (state_q != IDLE) && (state_q != RESP);

  jtag_tck_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tck_gen (
    .clk       (clk),
    .sys_rst   (sys_rst),
    .en        (tck_en),
    .tck       (TCK),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

  assign cmd_len_eff = (cmd_len > MAX_LEN6) ? MAX_LEN6 : cmd_len;

  assign cmd_ready  = (state_q == IDLE);
  assign rsp_valid  = (state_q == RESP);
  assign rsp_data   = rsp_data_q;
  assign TMS        = tms_q;
  assign TDI        = tdi_q;
  assign jtag_rst_n = jtag_rst_n_q;

  // TMS/TDI for the next bit are loaded on the falling-TCK tick that ends the
  // current bit, so the pins are stable across the following rising edge.
  always_comb begin
    state_d    = state_q;
    bit_d      = bit_q;
    len_d      = len_q;
    ir_d       = ir_q;
    cmd_rst_d  = cmd_rst_q;
    tms_d      = tms_q;
    tdi_d      = tdi_q;
    data_d     = data_q;
    cap_d      = cap_q;
    rsp_data_d = rsp_data_q;

    unique case (state_q)
      TAP_RST: begin
        if (fall_tick) begin
          if (bit_q == 6'(TAP_RST_BITS - 1)) begin
            // Only a commanded TAP reset produces a response.
            state_d    = cmd_rst_q ? RESP : IDLE;
            rsp_data_d = cmd_rst_q ? cap_q : rsp_data_q;
            bit_d      = '0;
            tms_d      = 1'b0;
          end else begin
            bit_d = bit_q + 6'd1;
            tms_d = (bit_q + 6'd2 != 6'(TAP_RST_BITS));
          end
        end
      end

      IDLE: begin
        if (cmd_valid) begin
          ir_d      = cmd_ir;
          len_d     = cmd_len_eff;
          data_d    = cmd_data;
          cap_d     = '0;
          bit_d     = '0;
          tdi_d     = 1'b0;
          tms_d     = 1'b1;
          cmd_rst_d = (cmd_len_eff == 6'd0);
          state_d   = (cmd_len_eff == 6'd0) ? TAP_RST : HDR;
        end
      end

      HDR: begin
        if (fall_tick) begin
          if (bit_q == hdr_bits(ir_q) - 6'd1) begin
            state_d = SHIFT;
            bit_d   = '0;
            tms_d   = (len_q == 6'd1);
            tdi_d   = data_q[0];
          end else begin
            bit_d = bit_q + 6'd1;
            tms_d = hdr_tms(ir_q, bit_q + 6'd1);
          end
        end
      end

      SHIFT: begin
        if (rise_tick) begin
          cap_d[bit_q[IDXW-1:0]] = TDO;
        end
        if (fall_tick) begin
          if (bit_q == len_q - 6'd1) begin
            state_d = TAIL;
            bit_d   = '0;
            tms_d   = 1'b1;
            tdi_d   = 1'b0;
          end else begin
            bit_d  = bit_q + 6'd1;
            // TMS rises on the last bit so its rising edge leaves for Exit1.
            tms_d  = (bit_q + 6'd2 == len_q);
            tdi_d  = data_q[1];
            data_d = data_q >> 1;
          end
        end
      end

      TAIL: begin
        if (fall_tick) begin
          tms_d = 1'b0;
          if (bit_q == 6'(TAIL_BITS - 1)) begin
            state_d    = RESP;
            bit_d      = '0;
            rsp_data_d = cap_q;
          end else begin
            bit_d = bit_q + 6'd1;
          end
        end
      end

      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = TAP_RST;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state_q      <= TAP_RST;
      bit_q        <= '0;
      len_q        <= '0;
      ir_q         <= 1'b0;
      cmd_rst_q    <= 1'b0;
      tms_q        <= 1'b1;
      tdi_q        <= 1'b0;
      data_q       <= '0;
      cap_q        <= '0;
      rsp_data_q   <= '0;
      jtag_rst_n_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_q        <= bit_d;
      len_q        <= len_d;
      ir_q         <= ir_d;
      cmd_rst_q    <= cmd_rst_d;
      tms_q        <= tms_d;
      tdi_q        <= tdi_d;
      data_q       <= data_d;
      cap_q        <= cap_d;
      rsp_data_q   <= rsp_data_d;
      jtag_rst_n_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_jtag_host_scan.sv
// -----------------------------------------------------------------------------
// tb_jtag_host_scan
// Directed plus randomized bench for jtag_host_scan. Expected pin sequences and
// responses come from a bit-list model of the scan rules and from a behavioural
// 16-state TAP with a 4-bit IR and a 32-bit IDCODE register. TDO is either
// looped back from TDI or driven by that TAP.
// -----------------------------------------------------------------------------
module tb_jtag_host_scan;

  localparam int          CLK_DIV  = 2;
  localparam int          MAX_LEN  = 32;
  localparam int          BIT_CLKS = 2 * CLK_DIV;
  localparam logic [31:0] IDCODE   = 32'h1BA00477;

  logic        clk       = 1'b0;
  logic        sys_rst   = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_ir    = 1'b0;
  logic [5:0]  cmd_len   = '0;
  logic [31:0] cmd_data  = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        tck, tms, tdi, tdo, jtag_rst_n;
  logic        loopback  = 1'b1;
  logic        tap_tdo   = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  bit rec_tms[$];
  bit rec_tdi[$];

  jtag_host_scan #(
    .CLK_DIV (CLK_DIV),
    .MAX_LEN (MAX_LEN)
  ) dut (
    .clk        (clk),
    .sys_rst    (sys_rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_ir     (cmd_ir),
    .cmd_len    (cmd_len),
    .cmd_data   (cmd_data),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .TCK        (tck),
    .TMS        (tms),
    .TDI        (tdi),
    .TDO        (tdo),
    .jtag_rst_n (jtag_rst_n)
  );

  always #5 clk = ~clk;

  assign tdo = loopback ? tdi : tap_tdo;

  // Pin values as seen by the target on each rising TCK edge.
  always @(posedge tck) begin
    rec_tms.push_back(tms);
    rec_tdi.push_back(tdi);
  end

  // ---------------------------------------------------------------- TAP model
  typedef enum int {
    TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
  } tap_e;

  tap_e        tap = TLR;
  logic [3:0]  tap_ir = 4'd1;
  logic [3:0]  ir_sr = '0;
  logic [31:0] dr_sr = '0;

  function automatic tap_e tap_next(input tap_e s, input logic m);
    case (s)
      TLR:     return m ? TLR    : RTI;
      RTI:     return m ? SEL_DR : RTI;
      SEL_DR:  return m ? SEL_IR : CAP_DR;
      CAP_DR:  return m ? EX1_DR : SH_DR;
      SH_DR:   return m ? EX1_DR : SH_DR;
      EX1_DR:  return m ? UPD_DR : PAU_DR;
      PAU_DR:  return m ? EX2_DR : PAU_DR;
      EX2_DR:  return m ? UPD_DR : SH_DR;
      UPD_DR:  return m ? SEL_DR : RTI;
      SEL_IR:  return m ? TLR    : CAP_IR;
      CAP_IR:  return m ? EX1_IR : SH_IR;
      SH_IR:   return m ? EX1_IR : SH_IR;
      EX1_IR:  return m ? UPD_IR : PAU_IR;
      PAU_IR:  return m ? EX2_IR : PAU_IR;
      EX2_IR:  return m ? UPD_IR : SH_IR;
      default: return m ? SEL_DR : RTI;
    endcase
  endfunction

  always @(posedge tck or negedge jtag_rst_n) begin
    if (!jtag_rst_n) begin
      tap    <= TLR;
      tap_ir <= 4'd1;
    end else begin
      case (tap)
        TLR:     tap_ir <= 4'd1;
        CAP_IR:  ir_sr  <= 4'b0001;
        SH_IR:   ir_sr  <= {tdi, ir_sr[3:1]};
        UPD_IR:  tap_ir <= ir_sr;
        CAP_DR:  dr_sr  <= (tap_ir == 4'd1) ? IDCODE : 32'd0;
        SH_DR:   dr_sr  <= (tap_ir == 4'd1) ? {tdi, dr_sr[31:1]} : {31'd0, tdi};
        default: ;
      endcase
      tap <= tap_next(tap, tms);
    end
  end

  always @(negedge tck) begin
    tap_tdo <= (tap == SH_IR) ? ir_sr[0] : (tap == SH_DR) ? dr_sr[0] : 1'b0;
  end

  // ------------------------------------------------------------ scan model
  // Expected TMS/TDI bit lists (index = TCK rising edge number).
  task automatic model_seq(input logic ir, input int len, input logic [31:0] data,
                           output int n, output logic [63:0] tv, output logic [63:0] dv);
    int l;
    l  = (len > MAX_LEN) ? MAX_LEN : len;
    n  = 0;
    tv = '0;
    dv = '0;
    if (l == 0) begin
      for (int i = 0; i < 5; i++) begin
        tv[n] = 1'b1;
        n++;
      end
      n++;
    end else begin
      // Select-DR (and Select-IR) on 1s, then Capture and Shift entry on 0s.
      for (int i = 0; i < (ir ? 2 : 1); i++) begin
        tv[n] = 1'b1;
        n++;
      end
      n += 2;
      for (int i = 0; i < l; i++) begin
        tv[n] = (i == l - 1);
        dv[n] = data[i];
        n++;
      end
      tv[n] = 1'b1;
      n += 2;
    end
  endtask

  function automatic logic [31:0] lb_exp(input int len, input logic [31:0] d);
    int          l;
    logic [31:0] m;
    l = (len > MAX_LEN) ? MAX_LEN : len;
    m = '0;
    for (int i = 0; i < l; i++) m[i] = d[i];
    return m;
  endfunction

  function automatic logic [63:0] pack_tms();
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < rec_tms.size() && i < 64; i++) v[i] = rec_tms[i];
    return v;
  endfunction

  function automatic logic [63:0] pack_tdi();
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < rec_tdi.size() && i < 64; i++) v[i] = rec_tdi[i];
    return v;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp)
    else begin
      n_errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "/tck"},        tck,        0);
    check({tag, "/tms"},        tms,        1);
    check({tag, "/tdi"},        tdi,        0);
    check({tag, "/cmd_ready"},  cmd_ready,  0);
    check({tag, "/rsp_valid"},  rsp_valid,  0);
    check({tag, "/rsp_data"},   rsp_data,   0);
    check({tag, "/jtag_rst_n"}, jtag_rst_n, 0);
  endtask

  task automatic check_seq(input string tag, input int n, input logic [63:0] tv,
                           input logic [63:0] dv);
    check({tag, "/nbits"}, rec_tms.size(), n);
    check({tag, "/tms"},   pack_tms(),     tv);
    check({tag, "/tdi"},   pack_tdi(),     dv);
  endtask

  // One full command/response transaction. hold = cycles rsp_ready stays low.
  task automatic run_cmd(input string tag, input logic ir, input int len,
                         input logic [31:0] data, input logic loop,
                         input logic [31:0] exp_rsp, input int hold);
    int          n;
    int          cyc;
    logic [63:0] tv, dv;
    logic [31:0] held;
    model_seq(ir, len, data, n, tv, dv);
    loopback = loop;
    cyc = 0;
    while (!cmd_ready && cyc < 500) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "/ready"}, cmd_ready, 1);
    rec_tms.delete();
    rec_tdi.delete();
    cmd_valid = 1'b1;
    cmd_ir    = ir;
    cmd_len   = 6'(len);
    cmd_data  = data;
    @(posedge clk); #1;
    // Scramble the command inputs: the engine must have latched them.
    cmd_valid = 1'b0;
    cmd_ir    = ~ir;
    cmd_len   = 6'($urandom);
    cmd_data  = $urandom;
    check({tag, "/busy"}, cmd_ready, 0);
    cyc = 0;
    while (!rsp_valid && cyc < 1000) begin
      @(posedge clk); #1;
      cyc++;
      cmd_valid = (cyc % 5 == 0);
    end
    cmd_valid = 1'b0;
    check({tag, "/latency"},  cyc,      BIT_CLKS * n);
    check({tag, "/rsp_data"}, rsp_data, exp_rsp);
    check_seq(tag, n, tv, dv);
    held = rsp_data;
    for (int k = 0; k < hold; k++) begin
      cmd_valid = k[0];
      cmd_data  = $urandom;
      cmd_len   = 6'($urandom_range(1, 32));
      @(posedge clk); #1;
      check({tag, "/hold_valid"}, rsp_valid, 1);
      check({tag, "/hold_data"},  rsp_data,  held);
      check({tag, "/hold_ready"}, cmd_ready, 0);
    end
    cmd_valid = 1'b0;
    check({tag, "/tck_idle"}, tck, 0);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check({tag, "/rsp_done"}, rsp_valid, 0);
    check({tag, "/ready_again"}, cmd_ready, 1);
    @(posedge clk); #1;
    check({tag, "/still_idle"}, cmd_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n, cyc, saw;
    logic [63:0] tv, dv;
    logic [31:0] d;
    logic        r_ir;
    int          r_len;

    // Reset state and the power-on TAP reset sequence.
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rec_tms.delete();
    rec_tdi.delete();
    sys_rst = 1'b0;
    cyc = 0;
    while (!cmd_ready && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("por/cycles_to_ready", cyc, 24);
    model_seq(1'b0, 0, 32'd0, n, tv, dv);
    check_seq("por", n, tv, dv);
    check("por/tck_low", tck, 0);
    check("por/jtag_rst_n", jtag_rst_n, 1);

    // Loopback DR scan.
    run_cmd("dr16_loop", 1'b0, 16, 32'h0000_1234, 1'b1, 32'h0000_1234, 0);

    // IR scan selecting IDCODE, then read it out of the TAP model.
    run_cmd("ir_idcode", 1'b1, 4, 32'h1, 1'b0, 32'h1, 0);
    run_cmd("dr_idcode", 1'b0, 32, 32'h0, 1'b0, IDCODE, 0);

    // Length boundaries.
    run_cmd("dr1", 1'b0, 1, 32'h1, 1'b1, 32'h1, 0);
    d = $urandom;
    run_cmd("dr40_clamp", 1'b0, 40, d, 1'b1, d, 0);
    d = $urandom;
    run_cmd("tap_rst_cmd", 1'b0, 0, d, 1'b1, 32'h0, 0);

    // Response back-pressure.
    d = $urandom;
    run_cmd("hold", 1'b1, 8, d, 1'b1, lb_exp(8, d), 10);

    // Randomized loopback scans.
    for (int i = 0; i < 10; i++) begin
      r_ir  = 1'($urandom_range(0, 1));
      r_len = $urandom_range(0, 40);
      d     = $urandom;
      run_cmd($sformatf("rand%0d", i), r_ir, r_len, d, 1'b1, lb_exp(r_len, d),
              $urandom_range(0, 3));
    end

    // Reset in the middle of SHIFT bit 5 of a 16-bit DR scan.
    loopback = 1'b1;
    cyc = 0;
    while (!cmd_ready && cyc < 500) begin
      @(posedge clk); #1;
      cyc++;
    end
    rec_tms.delete();
    rec_tdi.delete();
    cmd_valid = 1'b1;
    cmd_ir    = 1'b0;
    cmd_len   = 6'd16;
    cmd_data  = 32'h0000_BEEF;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cyc = 0;
    while (rec_tms.size() < 9 && cyc < 500) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("abort/reach_bit5", rec_tms.size(), 9);
    sys_rst = 1'b1;
    @(posedge clk); #1;
    check_reset_vals("abort");
    sys_rst = 1'b0;
    rec_tms.delete();
    rec_tdi.delete();
    cyc = 0;
    saw = 0;
    while (!cmd_ready && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (rsp_valid) saw = 1;
    end
    check("abort/cycles_to_ready", cyc, 24);
    model_seq(1'b0, 0, 32'd0, n, tv, dv);
    check_seq("abort_replay", n, tv, dv);
    repeat (5) begin
      @(posedge clk); #1;
      if (rsp_valid) saw = 1;
    end
    check("abort/no_rsp", saw, 0);

    // Normal operation after the abort.
    d = $urandom;
    run_cmd("post_abort", 1'b0, 16, d, 1'b1, lb_exp(16, d), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
